class_hvec_store: RTL and testbench
===================================

Name: class_hvec_store

Overview:
- Parametrised, writable store of class hypervectors. Each class vector is held as NUM_FRAMES frames of FRAME_W bits.
- Streams a requested class vector out frame by frame over a valid/ready interface.
- Accepts per-frame writes (overwrite or XOR-bind) so training can update class vectors in place.
- Sits between the training/update logic and the associative-search (similarity) stage.

Parameters:
- FRAME_W, 64, bits per frame.
- NUM_CLASSES, 8, number of class vectors; minimum 1.
- NUM_FRAMES, 3, frames per class vector; minimum 1.
- CID_W, $clog2(NUM_CLASSES) (minimum 1), class-id width. Localparam, derived.
- FIDX_W, $clog2(NUM_FRAMES) (minimum 1), frame-index width. Localparam, derived.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  read request valid.
- req_ready  out  1  store can accept a read request.
- req_class  in  CID_W  class to stream.
- out_valid  out  1  out_data holds a valid frame.
- out_ready  in  1  consumer accepts the frame.
- out_data  out  FRAME_W  frame contents.
- out_fidx  out  FIDX_W  index of the current frame.
- out_last  out  1  current frame is frame NUM_FRAMES-1.
- out_err  out  1  request carried an out-of-range class id.
- wr_en  in  1  write strobe, single cycle.
- wr_op  in  1  0 = overwrite, 1 = XOR into the stored frame.
- wr_class  in  CID_W  target class.
- wr_fidx  in  FIDX_W  target frame.
- wr_data  in  FRAME_W  write data.

Behaviour:
- Storage: NUM_CLASSES*NUM_FRAMES registers of FRAME_W bits. rst clears every entry to 0.
- Reset values: req_ready=0 while rst is high, then 1 in IDLE. out_valid=0, out_data=0, out_fidx=0, out_last=0, out_err=0. FSM returns to IDLE.
- Reset mid-stream aborts the burst; no partial completion after reset.
- FSM has two states, IDLE and STREAM.
- IDLE:
  - req_ready=1.
  - On req_valid: latch the class id, load out_data with mem[class][0], set out_fidx=0, set out_valid=1, go to STREAM.
  - Latency: first frame is valid 1 cycle after the accepting edge.
- STREAM:
  - req_ready=0.
  - On out_valid&&out_ready with out_fidx<NUM_FRAMES-1: increment out_fidx and load the next frame. This gives back-to-back frames, one per cycle, with no bubbles.
  - On out_valid&&out_ready with out_last=1: out_valid=0, go to IDLE. The next request can be accepted 1 cycle later.
- Stall: while out_valid && !out_ready, out_data, out_fidx, out_last and out_err hold stable, even if the entry is written meanwhile.
- out_last = (out_fidx==NUM_FRAMES-1) && out_valid.
- NUM_FRAMES=1: every burst is a single frame with out_last=1.
- Out-of-range read (req_class>=NUM_CLASSES):
  - The request is still accepted and a full burst of NUM_FRAMES frames is produced.
  - out_data=0 and out_err=1 on every frame of that burst.
  - out_err clears when the burst ends.
- Writes:
  - Always accepted and take effect at the clock edge.
  - wr_op=0: mem <= wr_data.
  - wr_op=1: mem <= mem ^ wr_data.
  - Writes with wr_class>=NUM_CLASSES or wr_fidx>=NUM_FRAMES are silently dropped.
- Write/read collision:
  - A frame load on the same edge as a write to that entry captures the OLD value (read-before-write).
  - A later frame of the same burst sees the new value.
- Simultaneous request and write in IDLE: both are performed; frame 0 follows the read-before-write rule.

Test Plan:
- Reset then write all 8x3 entries (value {class,fidx} replicated); request class 5 with out_ready=1 → 3 consecutive frames, fidx 0,1,2, last only on fidx 2, data matching; req_ready back to 1 one cycle after last.
- Stall: request class 2, hold out_ready=0 for 4 cycles and write 64'hFFFF_0000_FFFF_0000 to class 2 frame 0 during the stall → out_data stays at the old frame-0 value until accepted.
- XOR update: entry = 64'h00FF; write wr_op=1 with 64'h0F0F → subsequent read returns 64'h0FF0; a second identical XOR restores 64'h00FF.
- Collision: write class 3 frame 0 in the same cycle the class 3 request is accepted → frame 0 returns the old value; write frame 1 before its load → frame 1 returns the new value.
- Out-of-range: NUM_CLASSES=6, request class 7 → 3 frames of zeros with out_err=1; write to class 6 is dropped, and a read of class 5 is unaffected.
- Assert rst mid-burst after frame 1 → out_valid=0 immediately, all entries read back 0, first request after reset starts at fidx 0.

Source files
------------

// File: rtl/class_hvec_store.sv
// Writable store of class hypervectors, streamed out frame by frame on request.
// Latency: first frame valid 1 cycle after request accept, then one frame per cycle.
// Backpressure: out_ready low stalls the burst; frame outputs hold stable until accepted.
module class_hvec_store #(
   parameter int FRAME_W     = 64,
   parameter int NUM_CLASSES = 8,
   parameter int NUM_FRAMES  = 3,
   localparam int CID_W      = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1,
   localparam int FIDX_W     = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [CID_W-1:0]   req_class,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [FRAME_W-1:0] out_data,
   output logic [FIDX_W-1:0]  out_fidx,
   output logic               out_last,
   output logic               out_err,
   input  logic               wr_en,
   input  logic               wr_op,
   input  logic [CID_W-1:0]   wr_class,
   input  logic [FIDX_W-1:0]  wr_fidx,
   input  logic [FRAME_W-1:0] wr_data
);

   typedef enum logic {S_IDLE, S_STREAM} state_t;

   state_t               state_q, state_d;
   logic [FRAME_W-1:0]   mem_q [NUM_CLASSES][NUM_FRAMES];
   logic [FRAME_W-1:0]   mem_d [NUM_CLASSES][NUM_FRAMES];
   logic [CID_W-1:0]     cls_q, cls_d;
   logic                 valid_q, valid_d;
   logic                 err_q, err_d;
   logic [FIDX_W-1:0]    fidx_q, fidx_d;
   logic [FRAME_W-1:0]   data_q, data_d;

   logic                 wr_in_range;
   logic                 req_err;
   logic                 fidx_last;
   logic [FIDX_W-1:0]    fidx_nxt;

   assign wr_in_range = (int'(wr_class) < NUM_CLASSES) && (int'(wr_fidx) < NUM_FRAMES);
   assign req_err     = (int'(req_class) >= NUM_CLASSES);
   assign fidx_last   = (int'(fidx_q) == NUM_FRAMES - 1);
   assign fidx_nxt    = fidx_q + FIDX_W'(1);

   // Next storage contents: overwrite or XOR-bind one in-range entry; reads below use mem_q (old value).
   always_comb begin
      mem_d = mem_q;
      if (wr_en && wr_in_range) begin
         mem_d[wr_class][wr_fidx] = wr_op ? (mem_q[wr_class][wr_fidx] ^ wr_data) : wr_data;
      end
   end

   // Burst sequencing: accept a request in IDLE, step through frames on each accepted handshake.
   always_comb begin
      state_d = state_q;
      cls_d   = cls_q;
      valid_d = valid_q;
      err_d   = err_q;
      fidx_d  = fidx_q;
      data_d  = data_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               cls_d   = req_class;
               err_d   = req_err;
               fidx_d  = '0;
               data_d  = req_err ? '0 : mem_q[req_class][0];
               valid_d = 1'b1;
               state_d = S_STREAM;
            end
         end
         S_STREAM: begin
            if (valid_q && out_ready) begin
               if (fidx_last) begin
                  valid_d = 1'b0;
                  err_d   = 1'b0;
                  fidx_d  = '0;
                  data_d  = '0;
                  state_d = S_IDLE;
               end else begin
                  fidx_d = fidx_nxt;
                  data_d = err_q ? '0 : mem_q[cls_q][fidx_nxt];
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State, storage and registered frame outputs; reset clears everything and aborts any burst.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         mem_q   <= '{default: '0};
         cls_q   <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         fidx_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         mem_q   <= mem_d;
         cls_q   <= cls_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         fidx_q  <= fidx_d;
         data_q  <= data_d;
      end
   end

   assign req_ready = (state_q == S_IDLE) && !rst;
   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign out_fidx  = fidx_q;
   assign out_last  = fidx_last && valid_q;
   assign out_err   = err_q;

endmodule

// File: tb/tb_class_hvec_store.sv
// Bench for class_hvec_store with six classes of three 64-bit frames.
// Reference model is a plain 2-D array of frame values updated after each write edge.
// Outputs are sampled 1 time unit after the rising edge.
module tb_class_hvec_store;

   localparam int FW  = 64;
   localparam int NC  = 6;
   localparam int NF  = 3;
   localparam int CW  = 3;
   localparam int FXW = 2;

   logic           clk = 1'b0;
   logic           rst;
   logic           req_valid;
   logic           req_ready;
   logic [CW-1:0]  req_class;
   logic           out_valid;
   logic           out_ready;
   logic [FW-1:0]  out_data;
   logic [FXW-1:0] out_fidx;
   logic           out_last;
   logic           out_err;
   logic           wr_en;
   logic           wr_op;
   logic [CW-1:0]  wr_class;
   logic [FXW-1:0] wr_fidx;
   logic [FW-1:0]  wr_data;

   always #5 clk = ~clk;

   class_hvec_store #(.FRAME_W(FW), .NUM_CLASSES(NC), .NUM_FRAMES(NF)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_class(req_class),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_fidx(out_fidx), .out_last(out_last), .out_err(out_err),
      .wr_en(wr_en), .wr_op(wr_op), .wr_class(wr_class), .wr_fidx(wr_fidx), .wr_data(wr_data)
   );

   logic [FW-1:0] model [NC][NF];
   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic void model_wr(input int c, input int f, input bit op, input logic [FW-1:0] d);
      if (c < NC && f < NF) model[c][f] = op ? (model[c][f] ^ d) : d;
   endfunction

   function automatic logic [FW-1:0] ref_frame(input int c, input int f);
      return (c >= NC) ? '0 : model[c][f];
   endfunction

   task automatic wr(input int c, input int f, input bit op, input logic [FW-1:0] d);
      wr_en = 1'b1; wr_op = op; wr_class = CW'(c); wr_fidx = FXW'(f); wr_data = d;
   endtask

   // Write one entry over one clock edge, then update the model.
   task automatic wr_cycle(input int c, input int f, input bit op, input logic [FW-1:0] d);
      wr(c, f, op, d);
      @(posedge clk); #1;
      wr_en = 1'b0;
      model_wr(c, f, op, d);
   endtask

   // Full burst of class c. stall>=0: that many stall cycles on frame 0 only;
   // stall<0: random 0..2 stall cycles per frame. Each stall cycle carries a write
   // (directed if dirw, else random, possibly out of range).
   task automatic read_burst(input int c, input int stall, input bit dirw, input int dc,
                             input int df, input logic [FW-1:0] dd, output logic [FW-1:0] lastd);
      logic [FW-1:0] exp;
      int ns, rc, rf;
      bit rop;
      logic [FW-1:0] rd;
      chk("req_ready_idle", FW'(req_ready), 1);
      req_valid = 1'b1; req_class = CW'(c); out_ready = 1'b0;
      exp = ref_frame(c, 0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      lastd = '0;
      for (int f = 0; f < NF; f++) begin
         ns = (stall < 0) ? int'($urandom_range(0, 2)) : ((f == 0) ? stall : 0);
         for (int s = 0; s < ns; s++) begin
            if (dirw) begin
               rc = dc; rf = df; rop = 1'b0; rd = dd;
            end else begin
               rc = int'($urandom_range(0, 7)); rf = int'($urandom_range(0, 3));
               rop = 1'($urandom_range(0, 1)); rd = {$urandom, $urandom};
            end
            wr_cycle(rc, rf, rop, rd);
            chk("stall_hold_data", out_data, exp);
            chk("stall_hold_fidx", FW'(out_fidx), FW'(f));
         end
         chk("frame_valid", FW'(out_valid), 1);
         chk("frame_data", out_data, exp);
         chk("frame_fidx", FW'(out_fidx), FW'(f));
         chk("frame_last", FW'(out_last), FW'(f == NF - 1));
         chk("frame_err", FW'(out_err), FW'(c >= NC));
         chk("req_ready_busy", FW'(req_ready), 0);
         lastd = out_data;
         out_ready = 1'b1;
         if (f < NF - 1) exp = ref_frame(c, f + 1);
         @(posedge clk); #1;
         out_ready = 1'b0;
      end
      chk("valid_after_last", FW'(out_valid), 0);
      chk("err_after_last", FW'(out_err), 0);
      chk("req_ready_after_last", FW'(req_ready), 1);
   endtask

   initial begin
      logic [FW-1:0] ld, old0;
      rst = 1'b1; req_valid = 1'b0; req_class = '0; out_ready = 1'b0;
      wr_en = 1'b0; wr_op = 1'b0; wr_class = '0; wr_fidx = '0; wr_data = '0;
      for (int c = 0; c < NC; c++) for (int f = 0; f < NF; f++) model[c][f] = '0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req_ready", FW'(req_ready), 0);
      chk("rst_out_valid", FW'(out_valid), 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_fidx", FW'(out_fidx), 0);
      chk("rst_out_last", FW'(out_last), 0);
      chk("rst_out_err", FW'(out_err), 0);
      rst = 1'b0;
      #1;
      chk("post_rst_req_ready", FW'(req_ready), 1);
      @(posedge clk); #1;

      // Fill every id pair 0..7 x 0..2; classes 6 and 7 must be dropped
      for (int c = 0; c < 8; c++)
         for (int f = 0; f < NF; f++)
            wr_cycle(c, f, 1'b0, {8{8'(c * 16 + f)}});

      // Back-to-back burst of class 5
      read_burst(5, 0, 1'b0, 0, 0, '0, ld);
      chk("class5_last_frame", ld, {8{8'h52}});

      // Stall on frame 0 of class 2 while frame 0 is overwritten
      read_burst(2, 4, 1'b1, 2, 0, 64'hFFFF_0000_FFFF_0000, ld);
      read_burst(2, 0, 1'b0, 0, 0, '0, ld);

      // XOR update on class 1 frame 2
      wr_cycle(1, 2, 1'b0, 64'h00FF);
      wr_cycle(1, 2, 1'b1, 64'h0F0F);
      read_burst(1, 0, 1'b0, 0, 0, '0, ld);
      chk("xor_once", ld, 64'h0FF0);
      wr_cycle(1, 2, 1'b1, 64'h0F0F);
      read_burst(1, 0, 1'b0, 0, 0, '0, ld);
      chk("xor_twice", ld, 64'h00FF);

      // Collision: request and write of class 3 frame 0 on the same edge
      old0 = model[3][0];
      req_valid = 1'b1; req_class = 3'd3; out_ready = 1'b0;
      wr(3, 0, 1'b0, 64'hA5A5_A5A5_0000_1111);
      @(posedge clk); #1;
      req_valid = 1'b0; wr_en = 1'b0;
      model_wr(3, 0, 1'b0, 64'hA5A5_A5A5_0000_1111);
      chk("coll_frame0_old", out_data, old0);
      wr_cycle(3, 1, 1'b0, 64'h1234_5678_9ABC_DEF0);
      chk("coll_frame0_hold", out_data, old0);
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("coll_frame1_new", out_data, 64'h1234_5678_9ABC_DEF0);
      chk("coll_frame1_fidx", FW'(out_fidx), 1);
      @(posedge clk); #1;
      chk("coll_frame2_last", FW'(out_last), 1);
      chk("coll_frame2_data", out_data, model[3][2]);
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("coll_end_valid", FW'(out_valid), 0);
      read_burst(3, 0, 1'b0, 0, 0, '0, ld);

      // Out-of-range read and dropped writes
      read_burst(7, 0, 1'b0, 0, 0, '0, ld);
      read_burst(6, 1, 1'b0, 0, 0, '0, ld);
      wr_cycle(6, 0, 1'b0, 64'hDEAD_BEEF_DEAD_BEEF);
      wr_cycle(5, 3, 1'b0, 64'hDEAD_BEEF_DEAD_BEEF);
      read_burst(5, 0, 1'b0, 0, 0, '0, ld);

      // Randomized bursts with random stalls and writes
      for (int i = 0; i < 30; i++)
         read_burst(int'($urandom_range(0, 7)), -1, 1'b0, 0, 0, '0, ld);

      // Reset mid-burst after frame 1 is presented
      req_valid = 1'b1; req_class = 3'd4; out_ready = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      chk("pre_rst_fidx", FW'(out_fidx), 1);
      out_ready = 1'b0;
      rst = 1'b1;
      #1;
      chk("midrst_valid", FW'(out_valid), 0);
      chk("midrst_req_ready", FW'(req_ready), 0);
      chk("midrst_fidx", FW'(out_fidx), 0);
      for (int c = 0; c < NC; c++) for (int f = 0; f < NF; f++) model[c][f] = '0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      chk("after_rst_valid", FW'(out_valid), 0);
      for (int c = 0; c < NC; c++) read_burst(c, 0, 1'b0, 0, 0, '0, ld);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
